// File: rtl/seq_bin_to_7seg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_bin_to_7seg_pkg : segment codes, FSM states, decode helpers     |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
package seq_bin_to_7seg_pkg;

  // Bit order {a,b,c,d,e,f,g,dp}, active-high, dp never lit.
  localparam logic [7:0] SEG_0   = 8'hFC;
  localparam logic [7:0] SEG_1   = 8'h60;
  localparam logic [7:0] SEG_2   = 8'hDA;
  localparam logic [7:0] SEG_3   = 8'hF2;
  localparam logic [7:0] SEG_4   = 8'h66;
  localparam logic [7:0] SEG_5   = 8'hB6;
  localparam logic [7:0] SEG_6   = 8'hBE;
  localparam logic [7:0] SEG_7   = 8'hE4;
  localparam logic [7:0] SEG_8   = 8'hFE;
  localparam logic [7:0] SEG_9   = 8'hF6;
  localparam logic [7:0] SEG_OFF = 8'h00;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic logic [7:0] seg_decode(input logic [3:0] code);
    logic [7:0] seg;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_bin_to_7seg_bcd_digit_adj.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bcd_digit_adj : double-dabble digit correction (>=5 -> +3)          |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule
`default_nettype wire

// File: rtl/seq_bin_to_7seg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_bin_to_7seg : sequential W-bit binary to D-digit BCD/7-segment  |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module seq_bin_to_7seg #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic           I_clk,
  input  logic           I_rst_n,
  input  logic           I_start,
  input  logic [W-1:0]   I_bin,
  input  logic           I_blank,
  output logic           O_busy,
  output logic           O_done,
  output logic [4*D-1:0] O_bcd,
  output logic [8*D-1:0] O_seg
);

  import seq_bin_to_7seg_pkg::*;

  localparam int     CW      = $clog2(W + 1);
  localparam longint MAX_BIN = (longint'(1) << W) - 1;

  generate
    if (W < 1 || pow10(D) <= MAX_BIN) begin : g_range_err
      $error("seq_bin_to_7seg: D=%0d digits cannot hold a %0d-bit value", D, W);
    end
  endgenerate

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   shreg;
  logic [4*D-1:0] work, work_adj, work_shifted, bcd;
  logic           done;
  logic           last;
  logic           unused_msb;

  generate
    for (genvar k = 0; k < D; k++) begin : g_adj
      bcd_digit_adj u_adj (
        .din  (work[4*k +: 4]),
        .dout (work_adj[4*k +: 4])
      );
    end
  endgenerate

  // The top adjusted bit falls off; the elaboration check guarantees it is 0.
  assign {unused_msb, work_shifted} = {work_adj, shreg[W-1]};
  assign last = (cnt == CW'(1));

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (I_start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last)    state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      cnt   <= '0;
      shreg <= '0;
      work  <= '0;
      bcd   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (I_start) begin
            shreg <= I_bin;
            work  <= '0;
            cnt   <= CW'(W);
          end
        end
        ST_SHIFT: begin
          work  <= work_shifted;
          shreg <= shreg << 1;
          cnt   <= cnt - CW'(1);
          if (last) begin
            bcd  <= work_shifted;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign O_busy = (state == ST_SHIFT);
  assign O_done = done;
  assign O_bcd  = bcd;

  // Walk from the most significant digit down, tracking "all zero so far".
  always_comb begin
    logic lz;
    lz    = 1'b1;
    O_seg = '0;
    for (int k = D - 1; k >= 0; k--) begin
      lz = lz && (bcd[4*k +: 4] == 4'd0);
      if (I_blank && (k != 0) && lz) O_seg[8*k +: 8] = SEG_OFF;
      else                           O_seg[8*k +: 8] = seg_decode(bcd[4*k +: 4]);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_bin_to_7seg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_seq_bin_to_7seg : three configurations vs a decimal-arithmetic   |
// | reference model. Revision 1.0                                       |
// +--------------------------------------------------------------------+
module tb_seq_bin_to_7seg;

  localparam int NC = 3;
  localparam int WS [NC] = '{8, 4, 16};
  localparam int DS [NC] = '{3, 2, 5};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a [NC];
  logic        blank_a [NC];
  logic [31:0] bin_a   [NC];
  logic        busy_a  [NC];
  logic        done_a  [NC];
  logic [63:0] bcd_a   [NC];
  logic [63:0] seg_a   [NC];

  logic [11:0] bcd0;  logic [23:0] seg0;
  logic [7:0]  bcd1;  logic [15:0] seg1;
  logic [19:0] bcd2;  logic [39:0] seg2;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_bin_to_7seg #(.W(8), .D(3)) u_dut0 (
    .I_clk(clk), .I_rst_n(rst_n), .I_start(start_a[0]), .I_bin(bin_a[0][7:0]),
    .I_blank(blank_a[0]), .O_busy(busy_a[0]), .O_done(done_a[0]), .O_bcd(bcd0), .O_seg(seg0));
  seq_bin_to_7seg #(.W(4), .D(2)) u_dut1 (
    .I_clk(clk), .I_rst_n(rst_n), .I_start(start_a[1]), .I_bin(bin_a[1][3:0]),
    .I_blank(blank_a[1]), .O_busy(busy_a[1]), .O_done(done_a[1]), .O_bcd(bcd1), .O_seg(seg1));
  seq_bin_to_7seg #(.W(16), .D(5)) u_dut2 (
    .I_clk(clk), .I_rst_n(rst_n), .I_start(start_a[2]), .I_bin(bin_a[2][15:0]),
    .I_blank(blank_a[2]), .O_busy(busy_a[2]), .O_done(done_a[2]), .O_bcd(bcd2), .O_seg(seg2));

  assign bcd_a[0] = 64'(bcd0);  assign seg_a[0] = 64'(seg0);
  assign bcd_a[1] = 64'(bcd1);  assign seg_a[1] = 64'(seg1);
  assign bcd_a[2] = 64'(bcd2);  assign seg_a[2] = 64'(seg2);

  // Reference model: a conversion occupies W cycles, then the value is shown.
  logic m_busy  [NC];
  logic m_done  [NC];
  int   m_left  [NC];
  int   m_pend  [NC];
  int   m_shown [NC];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NC; i++) begin
      if (!rst_n) begin
        m_busy[i]  <= 1'b0;
        m_done[i]  <= 1'b0;
        m_left[i]  <= 0;
        m_pend[i]  <= 0;
        m_shown[i] <= 0;
      end else begin
        m_done[i] <= 1'b0;
        if (m_busy[i]) begin
          m_left[i] <= m_left[i] - 1;
          if (m_left[i] == 1) begin
            m_busy[i]  <= 1'b0;
            m_done[i]  <= 1'b1;
            m_shown[i] <= m_pend[i];
          end
        end else if (start_a[i]) begin
          m_busy[i] <= 1'b1;
          m_left[i] <= WS[i];
          m_pend[i] <= int'(bin_a[i] & ((32'd1 << WS[i]) - 32'd1));
        end
      end
    end
  end

  function automatic logic [7:0] seg_of(input int dig);
    case (dig)
      0: return 8'hFC;  1: return 8'h60;  2: return 8'hDA;  3: return 8'hF2;
      4: return 8'h66;  5: return 8'hB6;  6: return 8'hBE;  7: return 8'hE4;
      8: return 8'hFE;  9: return 8'hF6;  default: return 8'h00;
    endcase
  endfunction

  function automatic logic [63:0] exp_bcd(input int v, input int d);
    logic [63:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // A digit above the units is blank when the whole value is below 10**k.
  function automatic logic [63:0] exp_seg(input int v, input int d, input logic blank);
    logic [63:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < d; k++) begin
      if (blank && k > 0 && v < p) r[8*k +: 8] = 8'h00;
      else                         r[8*k +: 8] = seg_of((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input int c, input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL cfg%0d %s: got %h, expected %h (t=%0t)", c, name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NC; i++) begin
      chk(i, "busy", 64'(busy_a[i]), 64'(m_busy[i]));
      chk(i, "done", 64'(done_a[i]), 64'(m_done[i]));
      chk(i, "bcd",  bcd_a[i], exp_bcd(m_shown[i], DS[i]));
      chk(i, "seg",  seg_a[i], exp_seg(m_shown[i], DS[i], blank_a[i]));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
  endtask

  task automatic start_conv(input int c, input int v, output int lat);
    bin_a[c]   = 32'(v);
    start_a[c] = 1'b1;
    tick();
    start_a[c] = 1'b0;
    lat = 0;
    while (!done_a[c] && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int ndone;
    rst_n = 1'b0;
    for (int i = 0; i < NC; i++) begin
      start_a[i] = 1'b0;
      blank_a[i] = 1'b0;
      bin_a[i]   = '0;
    end
    repeat (3) tick();
    chk(0, "reset_busy", 64'(busy_a[0]), 64'd0);
    chk(0, "reset_done", 64'(done_a[0]), 64'd0);
    chk(0, "reset_bcd",  bcd_a[0], 64'd0);
    rst_n = 1'b1;
    tick();

    // 255 -> "255", done after exactly W cycles
    start_conv(0, 255, lat);
    chk(0, "lat_255", 64'(lat), 64'd8);
    chk(0, "bcd_255", bcd_a[0], 64'h255);
    chk(0, "seg_255", seg_a[0], 64'hDAB6B6);

    // zero with blanking, then unblank without a new conversion
    blank_a[0] = 1'b1;
    start_conv(0, 0, lat);
    chk(0, "bcd_0", bcd_a[0], 64'h0);
    chk(0, "seg_0_blank", seg_a[0], 64'h0000FC);
    blank_a[0] = 1'b0;
    tick();
    chk(0, "seg_0_unblank", seg_a[0], 64'hFCFCFC);
    chk(0, "no_done_unblank", 64'(done_a[0]), 64'd0);

    // starts while busy are ignored; start in the done cycle is accepted
    bin_a[0]   = 32'd7;
    start_a[0] = 1'b1;
    tick();
    for (int c = 1; c <= 8; c++) begin
      bin_a[0]   = 32'd123;
      start_a[0] = (c == 3 || c == 5);
      tick();
    end
    start_a[0] = 1'b0;
    chk(0, "done_7", 64'(done_a[0]), 64'd1);
    chk(0, "bcd_7", bcd_a[0], 64'h007);
    start_conv(0, 100, lat);
    chk(0, "lat_100", 64'(lat), 64'd8);
    chk(0, "bcd_100", bcd_a[0], 64'h100);

    // reset in the middle of a conversion
    start_conv(0, 42, lat);
    chk(0, "bcd_42", bcd_a[0], 64'h042);
    bin_a[0]   = 32'd99;
    start_a[0] = 1'b1;
    tick();
    start_a[0] = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk(0, "abort_busy", 64'(busy_a[0]), 64'd0);
    chk(0, "abort_done", 64'(done_a[0]), 64'd0);
    chk(0, "abort_bcd",  bcd_a[0], 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin
      tick();
      ndone += int'(done_a[0]);
    end
    chk(0, "no_done_after_abort", 64'(ndone), 64'd0);

    // W=4, D=2 full sweep
    for (int v = 0; v < 16; v++) begin
      blank_a[1] = (v == 13) ? 1'b0 : 1'($urandom_range(0, 1));
      start_conv(1, v, lat);
      if (v == 13) begin
        chk(1, "bcd_13", bcd_a[1], 64'h13);
        chk(1, "seg0_13", 64'(seg_a[1][7:0]), 64'hF2);
        chk(1, "seg1_13", 64'(seg_a[1][15:8]), 64'h60);
      end
    end

    // W=16, D=5 maximum
    start_conv(2, 65535, lat);
    chk(2, "lat_65535", 64'(lat), 64'd16);
    chk(2, "bcd_65535", bcd_a[2], 64'h65535);

    // randomized traffic on all configurations
    repeat (600) begin
      for (int i = 0; i < NC; i++) begin
        start_a[i] = ($urandom_range(0, 2) == 0);
        bin_a[i]   = $urandom;
        blank_a[i] = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    for (int i = 0; i < NC; i++) start_a[i] = 1'b0;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
